delay_timer_scheduler: RTL and testbench

//   Shares one delay-timer engine (4-bit delay, (delay+1)*TICK_CYCLES count) among NREQ requesters.

---
 rtl/delay_timer_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_delay_timer_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_scheduler.sv
// -----------------------------------------------------------------------------
// delay_timer_scheduler
//
// Purpose:
//   Shares a single delay-timer engine among NREQ requesters. An idle engine
//   picks the next requester round-robin and captures that requester's 4-bit
//   delay. It then counts (delay+1)*TICK_CYCLES clock cycles. Finally it holds
//   a one-hot done flag until the owning requester acknowledges it.
//
// Ports:
//   clk        in   1              system clock, rising edge
//   reset_n    in   1              asynchronous active-low reset
//   req        in   NREQ           per-requester timer request (level)
//   req_delay  in   NREQ*DELAY_W   delay of requester i at [i*DELAY_W +: DELAY_W]
//   ack        in   NREQ           per-requester acknowledge of done
//   grant      out  NREQ           one-hot engine owner, 0 when idle
//   busy       out  1              engine loading or counting
//   remaining  out  DELAY_W        delay units left while counting, else 0
//   done       out  NREQ           one-hot completion flag, held until ack
//
// Configuration macro:
//   TIMER_SCHED_ABORT_EN - when defined, the owner dropping its req while the
//   engine is loading or counting abandons the job. No done is raised and the
//   round-robin pointer moves past the owner.
//
// Every output comes straight from a register. No combinational path exists
// from req or ack to any output.
// -----------------------------------------------------------------------------
module delay_timer_scheduler #(
    parameter int NREQ        = 4,
    parameter int DELAY_W     = 4,
    parameter int TICK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DELAY_W-1:0]   req_delay,
    input  logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output logic [DELAY_W-1:0]        remaining,
    output logic [NREQ-1:0]           done
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int FC_W  = $clog2(TICK_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_CYCLES - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r,     state_s;
    logic [NREQ-1:0]      grant_r,     grant_s;
    logic [PTR_W-1:0]     gidx_r,      gidx_s;
    logic [PTR_W-1:0]     rr_ptr_r,    rr_ptr_s;
    logic [DELAY_W-1:0]   scount_r,    scount_s;
    logic [FC_W-1:0]      fcount_r,    fcount_s;
    logic                 busy_r,      busy_s;
    logic [DELAY_W-1:0]   remaining_r, remaining_s;
    logic [NREQ-1:0]      done_r,      done_s;

    logic                 found_s;
    logic [PTR_W-1:0]     sel_s;
    logic [DELAY_W-1:0]   delay_sel_s;
    logic [PTR_W-1:0]     next_ptr_s;

    // Round-robin search starting at rr_ptr, and selection of the winner's delay
    always_comb begin
        int idx;
        logic hit;
        idx         = 0;
        hit         = 1'b0;
        found_s     = 1'b0;
        sel_s       = '0;
        delay_sel_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx     = (int'(rr_ptr_r) + k) % NREQ;
            hit     = req[PTR_W'(idx)] && !found_s;
            sel_s   = hit ? PTR_W'(idx) : sel_s;
            found_s = found_s | hit;
        end
        for (int i = 0; i < NREQ; i++) begin
            delay_sel_s = (sel_s == PTR_W'(i)) ? req_delay[i*DELAY_W +: DELAY_W]
                                               : delay_sel_s;
        end
    end

    // Pointer value that makes the requester after the current owner the first candidate
    always_comb begin
        if (gidx_r == PTR_W'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_r + PTR_W'(1);
        end
    end

    // Next-state logic and registered-output precomputation
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        gidx_s   = gidx_r;
        rr_ptr_s = rr_ptr_r;
        scount_s = scount_r;
        fcount_s = fcount_r;

        case (state_r)
            IDLE: begin
                grant_s = '0;
                if (found_s) begin
                    state_s  = LOAD;
                    grant_s  = ONE_HOT0 << sel_s;
                    gidx_s   = sel_s;
                    scount_s = delay_sel_s;
                    fcount_s = '0;
                end else begin
                    state_s  = IDLE;
                end
            end
            LOAD: begin
                state_s  = COUNT;
                fcount_s = '0;
            end
            COUNT: begin
                if (fcount_r == FC_LAST) begin
                    if (scount_r == '0) begin
                        state_s = DONE;
                    end else begin
                        scount_s = scount_r - DELAY_W'(1);
                        fcount_s = '0;
                    end
                end else begin
                    fcount_s = fcount_r + FC_W'(1);
                end
            end
            DONE: begin
                // Only the owner's ack ends the job; other ack bits are ignored
                if (ack[gidx_r]) begin
                    state_s  = IDLE;
                    grant_s  = '0;
                    rr_ptr_s = next_ptr_s;
                end else begin
                    state_s  = DONE;
                end
            end
            default: begin
                state_s  = IDLE;
                grant_s  = '0;
                scount_s = '0;
                fcount_s = '0;
            end
        endcase

`ifdef TIMER_SCHED_ABORT_EN
        // Owner withdrew its request while the engine was running: drop the job silently
        if (((state_r == LOAD) || (state_r == COUNT)) && !req[gidx_r]) begin
            state_s  = IDLE;
            grant_s  = '0;
            rr_ptr_s = next_ptr_s;
        end else begin
            rr_ptr_s = rr_ptr_s;
        end
`endif

        busy_s      = (state_s == LOAD) || (state_s == COUNT);
        remaining_s = busy_s ? scount_s : '0;
        done_s      = (state_s == DONE) ? grant_s : '0;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            gidx_r      <= '0;
            rr_ptr_r    <= '0;
            scount_r    <= '0;
            fcount_r    <= '0;
            busy_r      <= 1'b0;
            remaining_r <= '0;
            done_r      <= '0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            gidx_r      <= gidx_s;
            rr_ptr_r    <= rr_ptr_s;
            scount_r    <= scount_s;
            fcount_r    <= fcount_s;
            busy_r      <= busy_s;
            remaining_r <= remaining_s;
            done_r      <= done_s;
        end
    end

    assign grant     = grant_r;
    assign busy      = busy_r;
    assign remaining = remaining_r;
    assign done      = done_r;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_scheduler
//
// Directed bench for delay_timer_scheduler with NREQ=4, DELAY_W=4 and
// TICK_CYCLES=4. Inputs change and outputs are sampled 1 time unit after each
// rising clock edge. Expected values are worked out by hand from the timer
// behaviour.
// -----------------------------------------------------------------------------
module tb_delay_timer_scheduler;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_delay;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  remaining;
    logic [3:0]  done;

    int n_cmp;
    int n_err;

    delay_timer_scheduler #(
        .NREQ        (4),
        .DELAY_W     (4),
        .TICK_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_delay (req_delay),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .remaining (remaining),
        .done      (done)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        req       = 4'b0000;
        req_delay = 16'h0000;
        ack       = 4'b0000;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_remaining", 32'(remaining), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // 1. single job, req[2], delay 3
        req            = 4'b0100;
        req_delay[11:8] = 4'd3;
        tick(1);
        chk("t1_load_grant", 32'(grant), 32'h4);
        chk("t1_load_busy", 32'(busy), 32'h1);
        chk("t1_load_rem", 32'(remaining), 32'h3);
        tick(1);
        for (int c = 0; c < 16; c++) begin
            chk("t1_cnt_busy", 32'(busy), 32'h1);
            chk("t1_cnt_rem", 32'(remaining), 32'(3 - c / 4));
            chk("t1_cnt_done", 32'(done), 32'h0);
            tick(1);
        end
        req = 4'b0000;
        chk("t1_done", 32'(done), 32'h4);
        chk("t1_done_busy", 32'(busy), 32'h0);
        chk("t1_done_rem", 32'(remaining), 32'h0);
        tick(3);
        chk("t1_done_held", 32'(done), 32'h4);
        chk("t1_grant_held", 32'(grant), 32'h4);
        ack = 4'b0100;
        tick(1);
        ack = 4'b0000;
        chk("t1_ack_done", 32'(done), 32'h0);
        chk("t1_ack_grant", 32'(grant), 32'h0);

        // 2. round-robin from a fresh pointer
        reset_n = 1'b0;
        tick(1);
        reset_n   = 1'b1;
        req       = 4'b1111;
        req_delay = 16'h0000;
        for (int j = 0; j < 5; j++) begin
            tick(1);
            chk("t2_grant", 32'(grant), 32'(4'b0001 << (j % 4)));
            chk("t2_load_busy", 32'(busy), 32'h1);
            tick(1);
            chk("t2_cnt_first", 32'(busy), 32'h1);
            tick(3);
            chk("t2_cnt_last", 32'(busy), 32'h1);
            tick(1);
            chk("t2_done", 32'(done), 32'(4'b0001 << (j % 4)));
            ack = done;
            tick(1);
            ack = 4'b0000;
            chk("t2_idle_grant", 32'(grant), 32'h0);
        end
        req = 4'b0000;

        // 3. delay freeze and contention (pointer now 1)
        req            = 4'b0010;
        req_delay[7:4] = 4'd2;
        tick(1);
        chk("t3_grant", 32'(grant), 32'h2);
        tick(1);
        tick(2);
        req_delay[7:4] = 4'd9;
        req            = 4'b1010;
        tick(1);
        chk("t3_frozen_rem", 32'(remaining), 32'h2);
        tick(8);
        chk("t3_cnt_last", 32'(busy), 32'h1);
        chk("t3_cnt_last_rem", 32'(remaining), 32'h0);
        tick(1);
        chk("t3_done", 32'(done), 32'h2);
        ack = 4'b0010;
        tick(1);
        ack = 4'b0000;
        chk("t3_idle", 32'(grant), 32'h0);
        req = 4'b1000;
        tick(1);
        chk("t3_regrant", 32'(grant), 32'h8);
        tick(5);
        chk("t3_done3", 32'(done), 32'h8);
        req = 4'b0000;
        ack = 4'b1000;
        tick(1);
        ack = 4'b0000;

        // 4. ack at count end and wrong ack (pointer now 0)
        req            = 4'b0001;
        req_delay[3:0] = 4'd1;
        tick(2);
        tick(7);
        ack = 4'b0001;
        tick(1);
        chk("t4_early_ack", 32'(done), 32'h1);
        req = 4'b0000;
        ack = 4'b0010;
        tick(2);
        chk("t4_wrong_ack", 32'(done), 32'h1);
        chk("t4_wrong_grant", 32'(grant), 32'h1);
        ack = 4'b0001;
        tick(1);
        ack = 4'b0000;
        chk("t4_ack_done", 32'(done), 32'h0);
        chk("t4_ack_grant", 32'(grant), 32'h0);

        // 5. reset in the fifth COUNT cycle (pointer now 1)
        req             = 4'b0100;
        req_delay[11:8] = 4'd3;
        tick(2);
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_rem", 32'(remaining), 32'h0);
        chk("t5_rst_done", 32'(done), 32'h0);
        tick(1);
        req     = 4'b1111;
        reset_n = 1'b1;
        tick(1);
        chk("t5_first_grant", 32'(grant), 32'h1);
        reset_n = 1'b0;
        tick(1);
        req       = 4'b0000;
        req_delay = 16'h0000;
        reset_n   = 1'b1;
        tick(1);

        // 6. owner drops req during COUNT
        req = 4'b0100;
        tick(2);
        tick(1);
        req = 4'b0000;
`ifdef TIMER_SCHED_ABORT_EN
        tick(1);
        chk("t6_abort_grant", 32'(grant), 32'h0);
        chk("t6_abort_busy", 32'(busy), 32'h0);
        tick(4);
        chk("t6_abort_done", 32'(done), 32'h0);
`else
        tick(3);
        chk("t6_done", 32'(done), 32'h4);
        ack = 4'b0100;
        tick(1);
        ack = 4'b0000;
        chk("t6_ack_done", 32'(done), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
